// File: rtl/handshake_arb_sender.sv
// handshake_arb_sender: round-robin N-channel 4-phase req/ack sender; HS_TIMEOUT_EN adds a per-phase timeout
module handshake_arb_sender #(
    parameter int WIDTH       = 4,
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [CHANNELS-1:0]            valid,
    input  logic [CHANNELS*WIDTH-1:0]      data_in,
    output logic [CHANNELS-1:0]            ready,
    input  logic                           ack,
    output logic                           req,
    output logic [WIDTH-1:0]               data_out,
    output logic [((CHANNELS>1) ? $clog2(CHANNELS) : 1)-1:0] chan_out,
    output logic                           busy,
    output logic                           timeout_err
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t                 state, state_d;
    logic                   req_d;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic [CW-1:0]          rr_ptr, grant;
    logic                   found, accept, tmo_hit, tmo;
    int                     idx;

    assign ack_s  = ack_sync[SYNC_STAGES-1];
    assign busy   = state != IDLE;
    assign ready  = (!reset && state == IDLE && found && !ack_s) ? (CHANNELS'(1) << grant) : '0;
    assign accept = |(valid & ready);

    // Bring the receiver's ack into the send clock domain
    always_ff @(posedge clk or posedge reset)
        if (reset) ack_sync <= '0;
        else       ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack};

    // Round-robin search: first valid channel at or above rr_ptr, wrapping to 0
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = 0;
        for (int k = 0; k < CHANNELS; k++) begin
            idx = (int'(rr_ptr) + k) % CHANNELS;
            if (!found && valid[idx]) begin
                found = 1'b1;
                grant = CW'(idx);
            end
        end
    end

    // Handshake sequencing: accept -> raise req -> wait ack_s -> drop req -> wait ack_s low
    always_comb begin
        state_d = state;
        req_d   = req;
        tmo     = 1'b0;
        case (state)
            IDLE: if (accept) begin
                state_d = REQ;
                req_d   = 1'b1;
            end
            REQ: if (ack_s || tmo_hit) begin
                state_d = DROP;
                req_d   = 1'b0;
                tmo     = !ack_s;
            end
            DROP: if (!ack_s || tmo_hit) begin
                state_d = IDLE;
                tmo     = ack_s;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and link request register
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            req   <= 1'b0;
        end else begin
            state <= state_d;
            req   <= req_d;
        end

    // Link data/channel captured only on accept so they stay stable through the handshake
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            data_out <= '0;
            chan_out <= '0;
            rr_ptr   <= '0;
        end else if (accept) begin
            data_out <= data_in[grant*WIDTH +: WIDTH];
            chan_out <= grant;
            rr_ptr   <= (grant == CW'(CHANNELS-1)) ? '0 : grant + 1'b1;
        end

`ifdef HS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] cnt;

    assign tmo_hit = (state != IDLE) && (cnt == TW'(TIMEOUT - 1));

    // Phase counter restarts on every state change and runs while a phase is pending
    always_ff @(posedge clk or posedge reset)
        if (reset)                 cnt <= '0;
        else if (state_d != state) cnt <= '0;
        else if (state != IDLE)    cnt <= cnt + 1'b1;

    // Sticky record that some handshake phase was abandoned
    always_ff @(posedge clk or posedge reset)
        if (reset)    timeout_err <= 1'b0;
        else if (tmo) timeout_err <= 1'b1;
`else
    logic unused_cfg;
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
    assign unused_cfg  = tmo | (TIMEOUT != 0);
`endif

endmodule

// File: tb/tb_handshake_arb_sender.sv
// tb_handshake_arb_sender: directed checks of arbitration, handshake timing, reset and timeout
module tb_handshake_arb_sender;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  valid = '0;
    logic [15:0] data_in = '0;
    logic [3:0]  ready;
    logic        ack = 1'b0;
    logic        req;
    logic [3:0]  data_out;
    logic [1:0]  chan_out;
    logic        busy;
    logic        timeout_err;
    int          compared = 0;
    int          mismatched = 0;

    handshake_arb_sender #(.WIDTH(4), .CHANNELS(4), .SYNC_STAGES(2), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .valid(valid), .data_in(data_in), .ready(ready),
        .ack(ack), .req(req), .data_out(data_out), .chan_out(chan_out),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Receiver side of one handshake, entered on the cycle req has just risen
    task automatic handshake(input int ch, input int d);
        ack = 1'b1;
        step();
        step();
        chk("req_held", 32'(req), 1);
        step();
        chk("req_fall", 32'(req), 0);
        chk("drop_busy", 32'(busy), 1);
        chk("drop_data", 32'(data_out), 32'(d));
        chk("drop_chan", 32'(chan_out), 32'(ch));
        ack = 1'b0;
        step();
        step();
        chk("drop_wait", 32'(busy), 1);
        step();
        chk("idle_busy", 32'(busy), 0);
        chk("idle_data", 32'(data_out), 32'(d));
        chk("idle_chan", 32'(chan_out), 32'(ch));
    endtask

    initial begin
        // reset state
        step(); step(); step();
        chk("rst_req", 32'(req), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_data", 32'(data_out), 0);
        chk("rst_chan", 32'(chan_out), 0);
        chk("rst_terr", 32'(timeout_err), 0);
        reset = 1'b0;
        step();

        // 1: single channel handshake
        valid = 4'b0001;
        data_in = 16'h000A;
        #1;
        chk("t1_ready", 32'(ready), 32'h1);
        step();
        chk("t1_req", 32'(req), 1);
        chk("t1_ready_off", 32'(ready), 0);
        chk("t1_data", 32'(data_out), 32'hA);
        chk("t1_chan", 32'(chan_out), 0);
        chk("t1_busy", 32'(busy), 1);
        valid = 4'b0000;
        step();
        step();
        chk("t1_stable", 32'(data_out), 32'hA);
        handshake(0, 'hA);

        reset = 1'b1;
        #1;
        step();
        reset = 1'b0;
        step();

        // 2: all channels contending, round robin with wrap
        valid = 4'b1111;
        data_in = 16'h4321;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("t2_ready", 32'(ready), 32'(1 << (i % 4)));
            step();
            chk("t2_req", 32'(req), 1);
            chk("t2_chan", 32'(chan_out), 32'(i % 4));
            chk("t2_data", 32'(data_out), 32'((i % 4) + 1));
            handshake(i % 4, (i % 4) + 1);
        end
        valid = 4'b0000;

        // 3: serve ch3 so the pointer wraps to 0, then lone ch2 wins
        valid = 4'b1000;
        #1;
        chk("t3_ready3", 32'(ready), 32'h8);
        step();
        chk("t3_chan3", 32'(chan_out), 3);
        valid = 4'b0000;
        handshake(3, 4);
        valid = 4'b0100;
        #1;
        chk("t3_ready2", 32'(ready), 32'h4);
        step();
        chk("t3_chan2", 32'(chan_out), 2);
        chk("t3_data2", 32'(data_out), 3);
        valid = 4'b0000;
        handshake(2, 3);

        // 4: reset in the middle of REQ
        valid = 4'b0010;
        #1;
        chk("t4_ready", 32'(ready), 32'h2);
        step();
        chk("t4_req", 32'(req), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t4_rst_req", 32'(req), 0);
        chk("t4_rst_busy", 32'(busy), 0);
        chk("t4_rst_terr", 32'(timeout_err), 0);
        chk("t4_rst_ready", 32'(ready), 0);
        step();
        reset = 1'b0;
        #1;
        chk("t4_ready_again", 32'(ready), 32'h2);
        step();
        chk("t4_req_again", 32'(req), 1);
        chk("t4_chan", 32'(chan_out), 1);
        chk("t4_data", 32'(data_out), 2);
        valid = 4'b0000;
        handshake(1, 2);

        // 5: stale ack blocks acceptance until it clears through the synchroniser
        ack = 1'b1;
        step(); step(); step();
        valid = 4'b0001;
        #1;
        chk("t5_blocked0", 32'(ready), 0);
        step();
        chk("t5_blocked1", 32'(ready), 0);
        chk("t5_noreq", 32'(req), 0);
        ack = 1'b0;
        step();
        chk("t5_blocked2", 32'(ready), 0);
        step();
        chk("t5_ready", 32'(ready), 32'h1);
        step();
        chk("t5_req", 32'(req), 1);
        chk("t5_chan", 32'(chan_out), 0);
        valid = 4'b0000;
        handshake(0, 1);

        // 6: receiver never acks
        valid = 4'b0001;
        #1;
        step();
        valid = 4'b0000;
`ifdef HS_TIMEOUT_EN
        for (int i = 1; i < 8; i++) begin
            step();
            chk("t6_req_wait", 32'(req), 1);
        end
        step();
        chk("t6_req_drop", 32'(req), 0);
        chk("t6_terr", 32'(timeout_err), 1);
        step();
        chk("t6_idle", 32'(busy), 0);
        chk("t6_terr_sticky", 32'(timeout_err), 1);
        valid = 4'b0001;
        #1;
        step();
        valid = 4'b0000;
        chk("t6_req_next", 32'(req), 1);
        handshake(0, 1);
        chk("t6_terr_end", 32'(timeout_err), 1);
`else
        for (int i = 0; i < 20; i++) step();
        chk("t6_req_hold", 32'(req), 1);
        chk("t6_terr_zero", 32'(timeout_err), 0);
        handshake(0, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
